seg_chase_decoder: RTL and testbench
====================================

Name: seg_chase_decoder

Overview:
- Monitors the active-low 8-bit segment bus driven by the figure-eight LED chaser and recovers the chase position from the segment patterns.
- Synchronises and glitch-filters the bus, decodes the patterns into a 3-bit position and disambiguates the doubly-used g segment from history.
- Measures the step period and flags illegal patterns and out-of-order steps.
- Sits on the input side of a second tile or test harness, as the receiving end of the chaser's display output.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples a pattern must hold before it is accepted (minimum 1).
- PERIOD_WIDTH, 16, width of the step-period measurement; the value saturates.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- seg_n  input  8  active-low segment bus, bit0=a … bit6=g, bit7=dp; asynchronous to clk
- clr_err  input  1  synchronous clear of the sticky error flags
- pos  output  3  decoded chase position
- pos_valid  output  1  decoder is locked and pos is meaningful
- step  output  1  one-cycle pulse on each legal +1 advance
- period  output  PERIOD_WIDTH  clocks between the last two accepted patterns, for a legal step
- period_valid  output  1  period holds a measurement taken since the last lock
- err_pattern  output  1  sticky: illegal pattern accepted
- err_seq  output  1  sticky: out-of-order step

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops, candidate register and accepted-pattern register reset to 8'hFF (blank).
  - State UNSYNC, cycle counter 0.
- Active-high pattern p = ~accepted seg_n. Position map:
  - a 8'h01 -> 0
  - b 8'h02 -> 1
  - g 8'h40 -> 2 or 6
  - e 8'h10 -> 3
  - d 8'h08 -> 4
  - c 8'h04 -> 5
  - f 8'h20 -> 7
- Filter:
  - 2-flop synchroniser, then candidate register cand plus a stability counter.
  - Sync output != cand: load cand, counter <= 0.
  - Otherwise the counter increments and saturates at STABLE_CYCLES-1.
  - Accept event when the counter == STABLE_CYCLES-1, sync output == cand, and cand != the accepted register. The accepted register loads cand.
- Latency: a new seg_n value held from before edge 1 updates the outputs at edge 3+STABLE_CYCLES (7 at default). Glitches shorter than STABLE_CYCLES samples never produce an event.
- Accept-event classification:
  - Blank (p == 0): go to UNSYNC, clear pos_valid and period_valid, no error.
  - Illegal (p not one-hot, or p == 8'h80): set err_pattern, go to UNSYNC, clear pos_valid and period_valid.
  - UNSYNC, non-g legal pattern: pos <= map, go to LOCKED, pos_valid <= 1, counter <= 1, no step.
  - UNSYNC, g: stay in UNSYNC; the position is ambiguous.
  - LOCKED, g: pos==1 -> 2; pos==5 -> 6. Any other pos: set err_seq, go to UNSYNC.
  - LOCKED, non-g: mapped == pos+1 (mod 8) is a legal step.
  - LOCKED, non-g, any other target: set err_seq, pos <= map, stay LOCKED, period_valid <= 0, no step.
- Legal step:
  - pos updates, step = 1 for one cycle.
  - period <= counter, period_valid <= 1, counter <= 1.
- Cycle counter: on cycles with no event while LOCKED, it increments, saturating at all-ones; period then reports the saturated value.
- Wrap: pos 7 -> 0 on pattern a is a legal step.
- clr_err clears both sticky flags. An error set in the same cycle wins.
- Reset mid-operation: immediate return to reset values.

Decomposition:
- Package seg_chase_pkg:
  - segment pattern constants SEG_A..SEG_DP and SEG_BLANK;
  - state enum {UNSYNC, LOCKED};
  - position constants.
- One sub-module, seg_input_filter: synchroniser plus stability counter, emitting the accepted pattern and a one-cycle event pulse.

Test Plan:
- Reset, then seg_n = ~8'h01 held 10 cycles -> outputs update at edge 7: pos=0, pos_valid=1, step=0, errors 0.
- Full chase 8'h01, 02, 40, 10, 08, 04, 40, 20, 01, each held 20 cycles -> positions 1,2,3,4,5,6,7,0 each with a step pulse. period=20 from the second step onward; both g's decode as 2 and 6.
- Glitch: while steady on 8'h02, drive 8'h40 for 3 cycles then back -> no event, pos stays 1, err flags 0.
- From pos 1, apply 8'h08 -> err_seq=1, pos=4, step=0, period_valid=0. Then clr_err -> err_seq=0.
- Apply 8'h03 or 8'h80 -> err_pattern=1, pos_valid=0. Then 8'h40 -> stays UNSYNC. Then 8'h10 -> LOCKED, pos=3.
- PERIOD_WIDTH=4 with a 40-cycle dwell -> period=15, saturated. Assert reset mid-dwell -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg_chase_pkg.sv
// Shared constants and types for the figure-eight chase decoder.
// Segment patterns are active-high (bit0=a ... bit6=g, bit7=dp).
package seg_chase_pkg;

    localparam logic [7:0] SEG_A       = 8'h01;
    localparam logic [7:0] SEG_B       = 8'h02;
    localparam logic [7:0] SEG_C       = 8'h04;
    localparam logic [7:0] SEG_D       = 8'h08;
    localparam logic [7:0] SEG_E       = 8'h10;
    localparam logic [7:0] SEG_F       = 8'h20;
    localparam logic [7:0] SEG_G       = 8'h40;
    localparam logic [7:0] SEG_DP      = 8'h80;
    localparam logic [7:0] SEG_BLANK   = 8'h00;
    localparam logic [7:0] SEG_BLANK_N = 8'hFF;

    localparam logic [2:0] POS_A       = 3'd0;
    localparam logic [2:0] POS_B       = 3'd1;
    localparam logic [2:0] POS_G_UPPER = 3'd2;
    localparam logic [2:0] POS_E       = 3'd3;
    localparam logic [2:0] POS_D       = 3'd4;
    localparam logic [2:0] POS_C       = 3'd5;
    localparam logic [2:0] POS_G_LOWER = 3'd6;
    localparam logic [2:0] POS_F       = 3'd7;

    typedef enum logic {
        UNSYNC = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // g maps to the upper crossing; the decoder resolves it from history.
    function automatic logic [2:0] seg_to_pos(input logic [7:0] p);
        logic [2:0] pos;
        case (p)
            SEG_A:   pos = POS_A;
            SEG_B:   pos = POS_B;
            SEG_G:   pos = POS_G_UPPER;
            SEG_E:   pos = POS_E;
            SEG_D:   pos = POS_D;
            SEG_C:   pos = POS_C;
            SEG_F:   pos = POS_F;
            default: pos = POS_A;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/seg_chase_decoder_if.sv
// Segment-bus and status bundle between the harness and the chase decoder.
interface seg_chase_decoder_if #(
    parameter int unsigned PERIOD_WIDTH = 16
);
    logic [7:0]              seg_n;
    logic                    clr_err;
    logic [2:0]              pos;
    logic                    pos_valid;
    logic                    step;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    err_pattern;
    logic                    err_seq;

    modport master (
        output seg_n,
        output clr_err,
        input  pos,
        input  pos_valid,
        input  step,
        input  period,
        input  period_valid,
        input  err_pattern,
        input  err_seq
    );

    modport slave (
        input  seg_n,
        input  clr_err,
        output pos,
        output pos_valid,
        output step,
        output period,
        output period_valid,
        output err_pattern,
        output err_seq
    );
endinterface

// File: rtl/seg_input_filter.sv
// Synchronises the asynchronous segment bus and accepts a pattern only after it
// has been stable for STABLE_CYCLES samples; emits a one-cycle accept pulse.
module seg_input_filter
    import seg_chase_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_seg_n,
    output logic [7:0] o_pattern,
    output logic       o_event
);
    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [7:0]    r_sync1;
    logic [7:0]    r_sync2;
    logic [7:0]    r_cand;
    logic [7:0]    r_accepted;
    logic [CW-1:0] r_cnt;
    logic          w_event;

    // Accept is combinational so the decoder registers it on the same edge
    // that the accepted register loads.
    assign w_event   = (r_cnt == CNT_MAX) && (r_sync2 == r_cand) && (r_cand != r_accepted);
    assign o_event   = w_event;
    assign o_pattern = ~r_cand;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1    <= SEG_BLANK_N;
            r_sync2    <= SEG_BLANK_N;
            r_cand     <= SEG_BLANK_N;
            r_accepted <= SEG_BLANK_N;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_seg_n;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_event) begin
                r_accepted <= r_cand;
            end
        end
    end

endmodule

// File: rtl/seg_chase_decoder.sv
// Recovers the figure-eight chase position from the filtered segment bus,
// measures the step period and flags illegal patterns and out-of-order steps.
module seg_chase_decoder
    import seg_chase_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned PERIOD_WIDTH  = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    seg_chase_decoder_if.slave bus
);
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = PERIOD_WIDTH'(1);

    logic [7:0]              w_pat;
    logic                    w_event;
    logic                    w_onehot;
    logic                    w_illegal;
    logic [2:0]              w_map;
    logic [2:0]              w_next;
    logic                    w_is_step;
    logic [2:0]              w_target;

    state_e                  r_state;
    logic [2:0]              r_pos;
    logic                    r_pos_valid;
    logic                    r_step;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_period_valid;
    logic                    r_err_pattern;
    logic                    r_err_seq;
    logic [PERIOD_WIDTH-1:0] r_cnt;

    seg_input_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_seg_n  (bus.seg_n),
        .o_pattern(w_pat),
        .o_event  (w_event)
    );

    always_comb begin
        w_onehot  = (w_pat != SEG_BLANK) && ((w_pat & (w_pat - 8'd1)) == 8'd0);
        w_illegal = !w_onehot || (w_pat == SEG_DP);
        w_map     = seg_to_pos(w_pat);
        w_next    = r_pos + 3'd1;
        w_is_step = 1'b0;
        w_target  = w_map;
        // g is only a legal successor of b (upper crossing) or c (lower crossing).
        if (w_pat == SEG_G) begin
            if (r_pos == POS_B) begin
                w_is_step = 1'b1;
                w_target  = POS_G_UPPER;
            end else if (r_pos == POS_C) begin
                w_is_step = 1'b1;
                w_target  = POS_G_LOWER;
            end
        end else begin
            w_is_step = (w_map == w_next);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= UNSYNC;
            r_pos          <= '0;
            r_pos_valid    <= 1'b0;
            r_step         <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_err_pattern  <= 1'b0;
            r_err_seq      <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_step <= 1'b0;
            if (bus.clr_err) begin
                r_err_pattern <= 1'b0;
                r_err_seq     <= 1'b0;
            end
            if (w_event) begin
                if (w_pat == SEG_BLANK) begin
                    r_state        <= UNSYNC;
                    r_pos_valid    <= 1'b0;
                    r_period_valid <= 1'b0;
                    r_cnt          <= '0;
                end else if (w_illegal) begin
                    r_err_pattern  <= 1'b1;
                    r_state        <= UNSYNC;
                    r_pos_valid    <= 1'b0;
                    r_period_valid <= 1'b0;
                    r_cnt          <= '0;
                end else if (r_state == UNSYNC) begin
                    if (w_pat != SEG_G) begin
                        r_pos       <= w_map;
                        r_state     <= LOCKED;
                        r_pos_valid <= 1'b1;
                        r_cnt       <= CNT_ONE;
                    end
                end else if (w_is_step) begin
                    r_pos          <= w_target;
                    r_step         <= 1'b1;
                    r_period       <= r_cnt;
                    r_period_valid <= 1'b1;
                    r_cnt          <= CNT_ONE;
                end else if (w_pat == SEG_G) begin
                    r_err_seq      <= 1'b1;
                    r_state        <= UNSYNC;
                    r_pos_valid    <= 1'b0;
                    r_period_valid <= 1'b0;
                    r_cnt          <= '0;
                end else begin
                    r_err_seq      <= 1'b1;
                    r_pos          <= w_map;
                    r_period_valid <= 1'b0;
                    r_cnt          <= CNT_ONE;
                end
            end else if ((r_state == LOCKED) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.pos          = r_pos;
    assign bus.pos_valid    = r_pos_valid;
    assign bus.step         = r_step;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.err_pattern  = r_err_pattern;
    assign bus.err_seq      = r_err_seq;

endmodule

// File: tb/tb_seg_chase_decoder.sv
// Self-checking bench: directed vector table, glitch/saturation/reset sequences
// and randomized pattern streams against a position-level reference model.
module tb_seg_chase_decoder;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    always #5 clk = ~clk;

    seg_chase_decoder_if #(.PERIOD_WIDTH(16)) bus ();
    seg_chase_decoder_if #(.PERIOD_WIDTH(4))  bus4 ();

    seg_chase_decoder #(
        .STABLE_CYCLES(4),
        .PERIOD_WIDTH (16)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    seg_chase_decoder #(
        .STABLE_CYCLES(4),
        .PERIOD_WIDTH (4)
    ) dut4 (
        .i_clk  (clk),
        .i_reset(rst4),
        .bus    (bus4)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pat;
        int         dwell;
        bit         clr;
        logic [2:0] pos;
        bit         valid;
        int         steps;
        bit         errp;
        bit         errs;
        bit         pvalid;
        int         period;
    } vec_t;

    vec_t vecs[$];

    // Chase order of active-high patterns, indexed by position.
    logic [7:0] chase [8] = '{8'h01, 8'h02, 8'h40, 8'h10, 8'h08, 8'h04, 8'h40, 8'h20};
    logic [7:0] pool [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00,
                              8'h80, 8'h03, 8'h41, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] pat, input int dwell, input bit clr,
                           input logic [2:0] pos, input bit valid, input int steps,
                           input bit errp, input bit errs, input bit pvalid, input int period);
        vec_t v;
        v.pat = pat; v.dwell = dwell; v.clr = clr; v.pos = pos; v.valid = valid;
        v.steps = steps; v.errp = errp; v.errs = errs; v.pvalid = pvalid; v.period = period;
        vecs.push_back(v);
    endtask

    // Drive active-high pattern p for d cycles; count step pulses seen.
    task automatic hold(input logic [7:0] p, input int d, input bit clr, output int steps);
        bus.seg_n   = ~p;
        bus.clr_err = clr;
        steps = 0;
        for (int c = 0; c < d; c++) begin
            @(posedge clk);
            #1;
            bus.clr_err = 1'b0;
            if (bus.step === 1'b1) steps++;
        end
    endtask

    task automatic check_main(input string tag, input bit valid, input logic [2:0] pos,
                              input int steps_act, input int steps_exp, input bit errp,
                              input bit errs, input bit pvalid, input int period);
        check({tag, " pos_valid"}, 32'(bus.pos_valid), 32'(valid));
        if (valid) check({tag, " pos"}, 32'(bus.pos), 32'(pos));
        check({tag, " steps"}, steps_act, steps_exp);
        check({tag, " err_pattern"}, 32'(bus.err_pattern), 32'(errp));
        check({tag, " err_seq"}, 32'(bus.err_seq), 32'(errs));
        check({tag, " period_valid"}, 32'(bus.period_valid), 32'(pvalid));
        check({tag, " period"}, 32'(bus.period), period);
    endtask

    // Reference model state (position-level view of the chase).
    bit   m_locked;
    int   m_pos;
    bit   m_errp;
    bit   m_errs;
    bit   m_pv;
    int   m_period;

    function automatic int pat_index(input logic [7:0] p);
        for (int k = 0; k < 8; k++) if (chase[k] == p) return k;
        return 0;
    endfunction

    task automatic model_event(input logic [7:0] p, input int prev_dwell, output int steps);
        steps = 0;
        if (p == 8'h00) begin
            m_locked = 0; m_pv = 0;
        end else if ($countones(p) != 1 || p == 8'h80) begin
            m_errp = 1; m_locked = 0; m_pv = 0;
        end else if (!m_locked) begin
            if (p != 8'h40) begin
                m_locked = 1; m_pos = pat_index(p);
            end
        end else if (chase[(m_pos + 1) % 8] == p) begin
            m_pos = (m_pos + 1) % 8;
            steps = 1;
            m_period = (prev_dwell > 65535) ? 65535 : prev_dwell;
            m_pv = 1;
        end else if (p == 8'h40) begin
            m_errs = 1; m_locked = 0; m_pv = 0;
        end else begin
            m_errs = 1; m_pos = pat_index(p); m_pv = 0;
        end
    endtask

    initial begin
        int         st;
        logic [7:0] prev;
        int         prev_dwell;

        rst = 1'b1; rst4 = 1'b1;
        bus.seg_n = 8'hFF; bus.clr_err = 1'b0;
        bus4.seg_n = 8'hFF; bus4.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 1'b0, 3'd0, 32'(bus.step), 0, 1'b0, 1'b0, 1'b0, 0);
        check("reset pos", 32'(bus.pos), 0);
        check("reset4 period", 32'(bus4.period), 0);

        // Lock latency: first pattern reaches the outputs at edge 7.
        rst = 1'b0;
        bus.seg_n = ~8'h01;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) check("latency edge6 pos_valid", 32'(bus.pos_valid), 0);
            if (c == 7) begin
                check("latency edge7 pos_valid", 32'(bus.pos_valid), 1);
                check("latency edge7 pos", 32'(bus.pos), 0);
                check("latency edge7 step", 32'(bus.step), 0);
                check("latency edge7 err_seq", 32'(bus.err_seq), 0);
            end
        end

        //      pat    dw  clr pos  v st ep es pv per
        add_vec(8'h02, 20, 0, 3'd1, 1, 1, 0, 0, 1, 20);
        add_vec(8'h40, 20, 0, 3'd2, 1, 1, 0, 0, 1, 20);
        add_vec(8'h10, 20, 0, 3'd3, 1, 1, 0, 0, 1, 20);
        add_vec(8'h08, 20, 0, 3'd4, 1, 1, 0, 0, 1, 20);
        add_vec(8'h04, 20, 0, 3'd5, 1, 1, 0, 0, 1, 20);
        add_vec(8'h40, 20, 0, 3'd6, 1, 1, 0, 0, 1, 20);
        add_vec(8'h20, 20, 0, 3'd7, 1, 1, 0, 0, 1, 20);
        add_vec(8'h01, 20, 0, 3'd0, 1, 1, 0, 0, 1, 20);
        add_vec(8'h02, 20, 0, 3'd1, 1, 1, 0, 0, 1, 20);
        add_vec(8'h08, 20, 0, 3'd4, 1, 0, 0, 1, 0, 20);
        add_vec(8'h08, 12, 1, 3'd4, 1, 0, 0, 0, 0, 20);
        add_vec(8'h80, 20, 0, 3'd0, 0, 0, 1, 0, 0, 20);
        add_vec(8'h40, 20, 0, 3'd0, 0, 0, 1, 0, 0, 20);
        add_vec(8'h10, 20, 0, 3'd3, 1, 0, 1, 0, 0, 20);
        add_vec(8'h08, 20, 0, 3'd4, 1, 1, 1, 0, 1, 20);
        add_vec(8'h03, 20, 0, 3'd0, 0, 0, 1, 0, 0, 20);
        add_vec(8'h03, 12, 1, 3'd0, 0, 0, 0, 0, 0, 20);
        add_vec(8'h01, 20, 0, 3'd0, 1, 0, 0, 0, 0, 20);
        add_vec(8'h40, 20, 0, 3'd0, 0, 0, 0, 1, 0, 20);
        add_vec(8'h00, 20, 0, 3'd0, 0, 0, 0, 1, 0, 20);
        add_vec(8'h02, 20, 0, 3'd1, 1, 0, 0, 1, 0, 20);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 9) begin
                // Short g glitch while steady on b must be ignored.
                hold(8'h40, 3, 1'b0, st);
                begin
                    int st2;
                    hold(8'h02, 20, 1'b0, st2);
                    check_main("glitch", 1'b1, 3'd1, st + st2, 0, 1'b0, 1'b0, 1'b1, 20);
                end
            end
            hold(vecs[i].pat, vecs[i].dwell, vecs[i].clr, st);
            check_main($sformatf("row%0d", i), vecs[i].valid, vecs[i].pos, st, vecs[i].steps,
                       vecs[i].errp, vecs[i].errs, vecs[i].pvalid, vecs[i].period);
        end

        // Randomized streams against the reference model.
        rst = 1'b1;
        bus.seg_n = 8'hFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_locked = 0; m_pos = 0; m_errp = 0; m_errs = 0; m_pv = 0; m_period = 0;
        prev = 8'h00;
        prev_dwell = 0;
        for (int n = 0; n < 200; n++) begin
            logic [7:0] p;
            int         d;
            bit         clr;
            int         exp_st;
            if (m_locked && $urandom_range(0, 9) < 6) p = chase[(m_pos + 1) % 8];
            else p = pool[$urandom_range(0, 11)];
            if (p == 8'hFF) p = 8'h00;
            if (p == prev) p = (prev == 8'h01) ? 8'h02 : 8'h01;
            d   = $urandom_range(8, 30);
            clr = ($urandom_range(0, 7) == 0);
            if (clr) begin
                m_errp = 0; m_errs = 0;
            end
            model_event(p, prev_dwell, exp_st);
            hold(p, d, clr, st);
            check_main($sformatf("rand%0d", n), m_locked, 3'(m_pos), st, exp_st,
                       m_errp, m_errs, m_pv, m_period);
            prev = p;
            prev_dwell = d;
        end

        // Narrow period counter saturates, then async reset clears everything.
        rst4 = 1'b0;
        bus4.seg_n = ~8'h01;
        repeat (40) @(posedge clk);
        #1;
        check("sat lock pos_valid", 32'(bus4.pos_valid), 1);
        bus4.seg_n = ~8'h02;
        st = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus4.step === 1'b1) st++;
        end
        check("sat pos", 32'(bus4.pos), 1);
        check("sat steps", st, 1);
        check("sat period", 32'(bus4.period), 15);
        check("sat period_valid", 32'(bus4.period_valid), 1);
        bus4.seg_n = ~8'h40;
        repeat (4) @(posedge clk);
        #2;
        rst4 = 1'b1;
        #1;
        check("midreset pos", 32'(bus4.pos), 0);
        check("midreset pos_valid", 32'(bus4.pos_valid), 0);
        check("midreset step", 32'(bus4.step), 0);
        check("midreset period", 32'(bus4.period), 0);
        check("midreset period_valid", 32'(bus4.period_valid), 0);
        check("midreset err_pattern", 32'(bus4.err_pattern), 0);
        check("midreset err_seq", 32'(bus4.err_seq), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
